sha256_compress: RTL and testbench

//  Responder end of the sha256_* block interface driven by the hash-message/thash controllers.

---
 rtl/sha256_compress.sv | 240 ++++++++++++++++++++++++
 tb/tb_sha256_compress.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sha256_compress.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_compress
//  Purpose  : SHA-256 compression engine, one round per cycle. Takes one
//             512-bit block and a 256-bit chaining state per start pulse.
//             On final blocks it applies MD padding from a running byte
//             counter and runs a second pass when the padding overflows.
//  Revision : 1.0  initial release
// ============================================================================
module sha256_compress #(
    parameter int CNT_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         sha256_start,
    input  logic         sha256_1st,
    input  logic         sha256_final,
    input  logic [255:0] sha256_state,
    input  logic [511:0] sha256_data,
    input  logic [6:0]   sha256_len,
    output logic         sha256_done,
    output logic [255:0] sha256_dout,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        ADD   = 2'd2
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Registered state (index 0 of wv is working variable a, 7 is h)
    state_t                 state_q, state_d;
    logic [5:0]             round_q, round_d;
    logic [31:0]            h_in_q [8];
    logic [31:0]            h_in_d [8];
    logic [31:0]            wv_q   [8];
    logic [31:0]            wv_d   [8];
    logic [31:0]            w_q    [16];
    logic [31:0]            w_d    [16];
    logic [511:0]           blk2_q, blk2_d;
    logic                   pass2_q, pass2_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [255:0]           dout_q, dout_d;

    // Padding datapath
    logic [6:0]             len_eff;
    logic [CNT_WIDTH-1:0]   cnt_new;
    logic [63:0]            bit_len;
    logic [511:0]           blk1;
    logic [511:0]           blk2;
    logic                   need2;

    // Round datapath
    logic [31:0]            t1;
    logic [31:0]            t2;
    logic [31:0]            w_new;
    logic [31:0]            sum [8];

    // Build the padded first block and, if the length field does not fit, the second block
    always_comb begin
        len_eff = (sha256_len > 7'd64) ? 7'd64 : sha256_len;
        cnt_new = (sha256_1st ? '0 : cnt_q)
                + (sha256_final ? CNT_WIDTH'(len_eff) : CNT_WIDTH'(64));
        bit_len = 64'(cnt_new) << 3;
        blk1    = sha256_data;
        blk2    = '0;
        need2   = 1'b0;
        if (sha256_final) begin
            for (int b = 0; b < 64; b++) begin
                if (7'(b) > len_eff) begin
                    blk1[511 - 8*b -: 8] = 8'h00;
                end else if (7'(b) == len_eff) begin
                    blk1[511 - 8*b -: 8] = 8'h80;
                end
            end
            if (len_eff <= 7'd55) begin
                blk1[63:0] = bit_len;
            end else begin
                need2       = 1'b1;
                blk2[63:0]  = bit_len;
                if (len_eff == 7'd64) begin
                    blk2[511:504] = 8'h80;
                end
            end
        end
    end

    // One SHA-256 round, next schedule word and the final feed-forward sums
    always_comb begin
        t1 = wv_q[7] + bsig1(wv_q[4]) + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]))
           + K[round_q] + w_q[0];
        t2 = bsig0(wv_q[0]) + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
        w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
        for (int i = 0; i < 8; i++) begin
            sum[i] = h_in_q[i] + wv_q[i];
        end
    end

    // Next-state logic for the control FSM and all datapath registers
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        h_in_d  = h_in_q;
        wv_d    = wv_q;
        w_d     = w_q;
        blk2_d  = blk2_q;
        pass2_d = pass2_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (sha256_start) begin
                    cnt_d   = cnt_new;
                    blk2_d  = blk2;
                    pass2_d = need2;
                    round_d = '0;
                    for (int i = 0; i < 8; i++) begin
                        h_in_d[i] = sha256_state[255 - 32*i -: 32];
                        wv_d[i]   = sha256_state[255 - 32*i -: 32];
                    end
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = blk1[511 - 32*i -: 32];
                    end
                    state_d = ROUND;
                end
            end
            ROUND: begin
                wv_d[7] = wv_q[6];
                wv_d[6] = wv_q[5];
                wv_d[5] = wv_q[4];
                wv_d[4] = wv_q[3] + t1;
                wv_d[3] = wv_q[2];
                wv_d[2] = wv_q[1];
                wv_d[1] = wv_q[0];
                wv_d[0] = t1 + t2;
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i + 1];
                end
                w_d[15] = w_new;
                round_d = round_q + 6'd1;
                if (round_q == 6'd63) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (pass2_q) begin
                    // Second pass chains from the first-pass sum
                    pass2_d = 1'b0;
                    round_d = '0;
                    for (int i = 0; i < 8; i++) begin
                        h_in_d[i] = sum[i];
                        wv_d[i]   = sum[i];
                    end
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = blk2_q[511 - 32*i -: 32];
                    end
                    state_d = ROUND;
                end else begin
                    done_d  = 1'b1;
                    dout_d  = {sum[0], sum[1], sum[2], sum[3], sum[4], sum[5], sum[6], sum[7]};
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            round_q <= '0;
            for (int i = 0; i < 8; i++) begin
                h_in_q[i] <= '0;
                wv_q[i]   <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            blk2_q  <= '0;
            pass2_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            h_in_q  <= h_in_d;
            wv_q    <= wv_d;
            w_q     <= w_d;
            blk2_q  <= blk2_d;
            pass2_q <= pass2_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign sha256_done = done_q;
    assign sha256_dout = dout_q;
    assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sha256_compress.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_compress
//  Purpose  : Directed, table-driven bench for sha256_compress using known
//             SHA-256 digests, plus chained, ignored-start and abort runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha256_compress;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_A64   = 256'hffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb;
    localparam logic [447:0] MSG56   = 448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071;
    localparam int WATCH = 140;

    logic         clk;
    logic         rstn;
    logic         sha256_start;
    logic         sha256_1st;
    logic         sha256_final;
    logic [255:0] sha256_state;
    logic [511:0] sha256_data;
    logic [6:0]   sha256_len;
    logic         sha256_done;
    logic [255:0] sha256_dout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    sha256_compress #(.CNT_WIDTH(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sha256_start (sha256_start),
        .sha256_1st   (sha256_1st),
        .sha256_final (sha256_final),
        .sha256_state (sha256_state),
        .sha256_data  (sha256_data),
        .sha256_len   (sha256_len),
        .sha256_done  (sha256_done),
        .sha256_dout  (sha256_dout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [255:0] st;
        logic [511:0] data;
        logic [6:0]   len;
        logic         first;
        logic         fin;
        logic [255:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Launch one block and watch WATCH cycles; cycle c means cycle T+c after the accept in cycle T
    task automatic run(input logic [255:0] st, input logic [511:0] data, input logic [6:0] len,
                       input logic first, input logic fin,
                       input int inj_a, input int inj_b, input int abort_at,
                       output logic [255:0] got, output int lat, output int ndone,
                       output logic busy1, output logic busy_done,
                       output logic [255:0] dout_end, output logic busy_end);
        got = '0; lat = 0; ndone = 0; busy1 = 1'b0; busy_done = 1'b1;
        @(posedge clk); #1;
        sha256_state = st; sha256_data = data; sha256_len = len;
        sha256_1st = first; sha256_final = fin; sha256_start = 1'b1;
        @(posedge clk); #1;
        sha256_start = 1'b0;
        for (int c = 1; c <= WATCH; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (c == 1) busy1 = busy;
            if (sha256_done) begin
                ndone++;
                if (lat == 0) begin
                    lat = c; got = sha256_dout; busy_done = busy;
                end
            end
            sha256_start = (c == inj_a) || (c == inj_b);
            if (sha256_start) begin
                sha256_data  = {16{$urandom}};
                sha256_state = {8{$urandom}};
                sha256_len   = 7'($urandom_range(0, 127));
                sha256_1st   = 1'b1;
                sha256_final = 1'b1;
            end
            rstn = (c != abort_at);
        end
        @(posedge clk); #1;
        sha256_start = 1'b0;
        rstn = 1'b1;
        dout_end = sha256_dout;
        busy_end = busy;
    endtask

    logic [255:0] got, dout_end, first_dout;
    int           lat, ndone;
    logic         busy1, busy_done, busy_end;

    initial begin
        rstn = 1'b0; sha256_start = 1'b0; sha256_1st = 1'b0; sha256_final = 1'b0;
        sha256_state = '0; sha256_data = '0; sha256_len = '0;

        vecs[0] = '{"abc",       IV, {24'h616263, 488'h0},               7'd3,   1'b1, 1'b1, D_ABC,   66};
        vecs[1] = '{"abc_junk",  IV, {24'h616263, {61{8'hA5}}},          7'd3,   1'b1, 1'b1, D_ABC,   66};
        vecs[2] = '{"empty",     IV, {64{8'h5A}},                        7'd0,   1'b1, 1'b1, D_EMPTY, 66};
        vecs[3] = '{"len56",     IV, {MSG56, 64'hdeadbeefcafef00d},      7'd56,  1'b1, 1'b1, D_56,    131};
        vecs[4] = '{"len64",     IV, {64{8'h61}},                        7'd64,  1'b1, 1'b1, D_A64,   131};
        vecs[5] = '{"len100",    IV, {64{8'h61}},                        7'd100, 1'b1, 1'b1, D_A64,   131};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 256'(sha256_done), 256'd0);
        chk("reset_dout", sha256_dout, 256'd0);
        chk("reset_busy", 256'(busy), 256'd0);
        rstn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run(vecs[v].st, vecs[v].data, vecs[v].len, vecs[v].first, vecs[v].fin, 0, 0, 0,
                got, lat, ndone, busy1, busy_done, dout_end, busy_end);
            chk({vecs[v].name, "_lat"},       256'(lat),   256'(vecs[v].lat));
            chk({vecs[v].name, "_ndone"},     256'(ndone), 256'd1);
            chk({vecs[v].name, "_dout"},      got,         vecs[v].exp);
            chk({vecs[v].name, "_busy1"},     256'(busy1), 256'd1);
            chk({vecs[v].name, "_busy_done"}, 256'(busy_done), 256'd0);
            chk({vecs[v].name, "_hold"},      dout_end,    vecs[v].exp);
        end

        // Two-block message: non-final 64 'a' then an empty final block
        run(IV, {64{8'h61}}, 7'd9, 1'b1, 1'b0, 0, 0, 0,
            first_dout, lat, ndone, busy1, busy_done, dout_end, busy_end);
        chk("chain1_lat",   256'(lat),   256'd66);
        chk("chain1_ndone", 256'(ndone), 256'd1);
        run(first_dout, {16{32'h0badf00d}}, 7'd0, 1'b0, 1'b1, 0, 0, 0,
            got, lat, ndone, busy1, busy_done, dout_end, busy_end);
        chk("chain2_lat",   256'(lat),   256'd66);
        chk("chain2_dout",  got,         D_A64);

        // Start pulses while busy are ignored
        run(IV, {24'h616263, 488'h0}, 7'd3, 1'b1, 1'b1, 5, 64, 0,
            got, lat, ndone, busy1, busy_done, dout_end, busy_end);
        chk("ignore_lat",   256'(lat),   256'd66);
        chk("ignore_ndone", 256'(ndone), 256'd1);
        chk("ignore_dout",  got,         D_ABC);

        // Reset mid-run aborts silently
        run(IV, {24'h616263, 488'h0}, 7'd3, 1'b1, 1'b1, 0, 0, 30,
            got, lat, ndone, busy1, busy_done, dout_end, busy_end);
        chk("abort_ndone", 256'(ndone),    256'd0);
        chk("abort_dout",  dout_end,       256'd0);
        chk("abort_busy",  256'(busy_end), 256'd0);

        run(IV, {24'h616263, 488'h0}, 7'd3, 1'b1, 1'b1, 0, 0, 0,
            got, lat, ndone, busy1, busy_done, dout_end, busy_end);
        chk("post_abort_lat",  256'(lat), 256'd66);
        chk("post_abort_dout", got,       D_ABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
